// File: rtl/sm_config_pkg.sv
// rtl/sm_config_pkg.sv - shared types, addresses and helpers for the surveillance-module config register file
package sm_config_pkg;

  localparam logic [11:0] REG_ADDR           = 12'h000;
  localparam logic [11:0] REG_OVERRUN        = 12'h004;
  localparam logic [11:0] DEF_MAXCLKCNT_ADDR = 12'h200;
  localparam logic [11:0] DEF_CFG_BASE       = 12'h300;
  localparam logic [11:0] DEF_LOT_BASE       = 12'h400;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  typedef enum logic [1:0] {
    ST_ADDR  = 2'd0,
    ST_LOW   = 2'd1,
    ST_HIGH  = 2'd2,
    ST_DRAIN = 2'd3
  } dbg_state_e;

  // One 32-bit LOT word per 32 tiles, rounded up.
  function automatic int lot_words(input int num_tiles);
    return ((num_tiles - 1) / 32) + 1;
  endfunction

endpackage

// File: rtl/sm_dirty_prienc.sv
// rtl/sm_dirty_prienc.sv - lowest-index-first priority encoder over the dirty vector
module sm_dirty_prienc
  import sm_config_pkg::*;
#(
  parameter int W  = 8,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  d_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan downwards so the lowest set bit is the last to win.
  always_comb begin
    idx_o   = '0;
    valid_o = |d_i;
    for (int i = W - 1; i >= 0; i--) begin
      if (d_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/sm_config_regfile.sv
// rtl/sm_config_regfile.sv - DII-written config register file with dirty-flag IRQ and Wishbone readback
// Optional overrun counter at 12'h004 when SM_CONFIG_REGFILE_OVERRUN_EN is defined.
module sm_config_regfile
  import sm_config_pkg::*;
#(
  parameter int          NUM_TILES      = 9,
  parameter int          NUM_CFG_REGS   = 6,
  parameter logic [11:0] CFG_BASE       = DEF_CFG_BASE,
  parameter logic [11:0] LOT_BASE       = DEF_LOT_BASE,
  parameter logic [11:0] MAXCLKCNT_ADDR = DEF_MAXCLKCNT_ADDR
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  dii_flit                   dii_flit_in,
  input  logic [31:0]               wb_addr,
  input  logic                      wb_cyc,
  input  logic                      wb_stb,
  input  logic                      wb_we,
  input  logic [31:0]               wb_data_in,
  input  logic [3:0]                wb_sel,
  input  logic                      wb_cab,
  input  logic [2:0]                wb_cti,
  input  logic [1:0]                wb_bte,
  output logic                      wb_ack,
  output logic                      wb_err,
  output logic                      wb_rty,
  output logic [31:0]               wb_data_out,
  output logic [31:0]               max_clk_counter,
  output logic [NUM_CFG_REGS*32-1:0] cfg_regs,
  output logic                      irq
);

  localparam int NUM_LOT_REG = lot_words(NUM_TILES);
  localparam int ND          = NUM_CFG_REGS + NUM_LOT_REG;
  localparam int IW          = (ND > 1) ? $clog2(ND) : 1;

  typedef struct packed {
    logic          hit;
    logic [IW-1:0] idx;
  } dec_t;

  // Maps a byte address onto the combined CFG+LOT index space.
  function automatic dec_t reg_decode(input logic [11:0] a);
    dec_t        r;
    logic [31:0] ca;
    logic [31:0] la;
    r  = '0;
    ca = {20'b0, a} - {20'b0, CFG_BASE};
    la = {20'b0, a} - {20'b0, LOT_BASE};
    if (a[1:0] == 2'b00) begin
      if ((a >= CFG_BASE) && ((ca >> 2) < 32'(NUM_CFG_REGS))) begin
        r.hit = 1'b1;
        r.idx = IW'(ca >> 2);
      end else if ((a >= LOT_BASE) && ((la >> 2) < 32'(NUM_LOT_REG))) begin
        r.hit = 1'b1;
        r.idx = IW'((la >> 2) + 32'(NUM_CFG_REGS));
      end
    end
    return r;
  endfunction

  dbg_state_e     state_q;
  logic [11:0]    addr_q;
  logic [15:0]    low_q;
  logic [31:0]    regs_q [ND];
  logic [31:0]    maxclk_q;
  logic [ND-1:0]  dirty_q;
  logic [ND-1:0]  dirty_d;
  logic           irq_q;

  logic           wr_fire;
  logic [31:0]    wr_data;
  dec_t           wr_dec;
  dec_t           rd_dec;
  logic           rd_clr;
  logic [IW-1:0]  enc_idx;
  logic           enc_valid;
  logic [11:0]    read_addr;
  logic           unused_inputs;

`ifdef SM_CONFIG_REGFILE_OVERRUN_EN
  logic [7:0]     ovr_q;
  logic [7:0]     ovr_d;
  logic           ovr_clr;
  logic           ovr_inc;
`endif

  assign unused_inputs = ^{wb_addr[31:12], wb_data_in, wb_sel, wb_cab, wb_cti, wb_bte};

  // Debug packet parser: address flit, low half, high half (last).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ADDR;
      addr_q  <= '0;
      low_q   <= '0;
    end else if (dii_flit_in.valid) begin
      case (state_q)
        ST_ADDR: begin
          if (!dii_flit_in.last) begin
            addr_q  <= dii_flit_in.data[11:0];
            state_q <= ST_LOW;
          end
        end
        ST_LOW: begin
          low_q   <= dii_flit_in.data;
          state_q <= dii_flit_in.last ? ST_DRAIN : ST_HIGH;
        end
        ST_HIGH: begin
          state_q <= dii_flit_in.last ? ST_ADDR : ST_DRAIN;
        end
        default: begin
          if (dii_flit_in.last) state_q <= ST_ADDR;
        end
      endcase
    end
  end

  assign wr_fire = (state_q == ST_HIGH) && dii_flit_in.valid && dii_flit_in.last;
  assign wr_data = {dii_flit_in.data, low_q};
  assign wr_dec  = reg_decode(addr_q);
  assign rd_dec  = reg_decode(wb_addr[11:0]);

  sm_dirty_prienc #(
    .W  (ND),
    .IW (IW)
  ) u_prienc (
    .d_i     (dirty_q),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  always_comb begin
    read_addr = '0;
    if (enc_valid) begin
      if (32'(enc_idx) < 32'(NUM_CFG_REGS)) begin
        read_addr = CFG_BASE + 12'({enc_idx, 2'b00});
      end else begin
        read_addr = LOT_BASE + 12'((32'(enc_idx) - 32'(NUM_CFG_REGS)) << 2);
      end
    end
  end

  always_comb begin
    wb_ack      = 1'b0;
    wb_err      = 1'b0;
    wb_data_out = '0;
    rd_clr      = 1'b0;
`ifdef SM_CONFIG_REGFILE_OVERRUN_EN
    ovr_clr     = 1'b0;
`endif
    if (wb_cyc && wb_stb) begin
      if (wb_we) begin
        wb_err = 1'b1;
      end else if (wb_addr[11:0] == REG_ADDR) begin
        wb_ack      = 1'b1;
        wb_data_out = {20'b0, read_addr};
`ifdef SM_CONFIG_REGFILE_OVERRUN_EN
      end else if (wb_addr[11:0] == REG_OVERRUN) begin
        wb_ack      = 1'b1;
        wb_data_out = {24'b0, ovr_q};
        ovr_clr     = 1'b1;
`endif
      end else if (rd_dec.hit) begin
        wb_ack      = 1'b1;
        wb_data_out = regs_q[rd_dec.idx];
        rd_clr      = 1'b1;
      end else begin
        wb_err = 1'b1;
      end
    end
  end

  // A debug write landing in the same cycle as a clearing read keeps the flag set.
  always_comb begin
    dirty_d = dirty_q;
    if (rd_clr) dirty_d[rd_dec.idx] = 1'b0;
    if (wr_fire && wr_dec.hit) dirty_d[wr_dec.idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ND; i++) regs_q[i] <= '0;
      maxclk_q <= '0;
      dirty_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_fire && wr_dec.hit) regs_q[wr_dec.idx] <= wr_data;
      if (wr_fire && (addr_q == MAXCLKCNT_ADDR)) maxclk_q <= wr_data;
      dirty_q <= dirty_d;
      irq_q   <= |dirty_d;
    end
  end

`ifdef SM_CONFIG_REGFILE_OVERRUN_EN
  assign ovr_inc = wr_fire && wr_dec.hit && dirty_q[wr_dec.idx] &&
                   !(rd_clr && (rd_dec.idx == wr_dec.idx));

  always_comb begin
    ovr_d = ovr_q;
    if (ovr_inc) begin
      if (ovr_clr)              ovr_d = 8'd1;
      else if (ovr_q != 8'hFF)  ovr_d = ovr_q + 8'd1;
    end else if (ovr_clr) begin
      ovr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_q <= '0;
    else        ovr_q <= ovr_d;
  end
`endif

  for (genvar g = 0; g < NUM_CFG_REGS; g++) begin : g_cfg_out
    assign cfg_regs[g*32 +: 32] = regs_q[g];
  end

  assign max_clk_counter = maxclk_q;
  assign irq             = irq_q;
  assign wb_rty          = 1'b0;

endmodule

// File: doc/sm_config_regfile.md
Name: sm_config_regfile

Overview:
- Parametrised configuration register file for the surveillance module tile.
- The debug side writes N generic 32-bit core configuration registers, the tile list (LOT) and module registers via DII event packets.
- Per-register dirty flags raise a core IRQ. The core reads REG_ADDR over Wishbone to get the lowest-indexed pending register, then reads that register, which clears its flag.
- Sits between the DII debug interface and the tile core's Wishbone bus; replaces the fixed six-register configuration block.

Parameters:
- NUM_TILES, 9, number of NoC tiles; NUM_LOT_REG = ((NUM_TILES-1)/32)+1 (localparam).
- NUM_CFG_REGS, 6, number of generic core configuration registers (1..64).
- CFG_BASE, 12'h300, byte address of configuration register 0; register i is at CFG_BASE + 4*i.
- LOT_BASE, 12'h400, byte address of LOT word 0; word j is at LOT_BASE + 4*j.
- MAXCLKCNT_ADDR, 12'h200, module-only register (debug write only).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- dii_flit_in  in  dii_flit  debug write packets (valid, last, 16-bit data)
- wb_addr  in  32  Wishbone byte address (bits 11:0 decoded)
- wb_cyc, wb_stb, wb_we  in  1 each  Wishbone control
- wb_data_in, wb_sel, wb_cab, wb_cti, wb_bte  in  32/4/1/3/2  unused
- wb_ack, wb_err, wb_rty  out  1 each  Wishbone response; wb_rty tied to 0
- wb_data_out  out  32  read data
- max_clk_counter  out  32  module register value
- cfg_regs  out  NUM_CFG_REGS*32  parallel view of configuration registers
- irq  out  1  any dirty flag set

Interface: one clock, clk; reset rst_n is asynchronous and active-low. All flops clear to 0 on reset, including every register, every dirty flag, the FSM (which goes to ADDR), and irq.

Behaviour:
- Debug FSM (ADDR, LOW, HIGH, DRAIN):
  - ADDR: on valid & !last, latch data[11:0] as the byte address and go to LOW. valid & last is ignored (single-flit packet).
  - LOW: on valid, latch the low word and go to HIGH; if last, go to DRAIN with no write.
  - HIGH: on valid & last, write {data, low} to the addressed register and go to ADDR. On valid & !last, go to DRAIN with no write.
  - DRAIN: on valid & last, go to ADDR.
- Write decode:
  - MAXCLKCNT_ADDR: write the register; no dirty flag.
  - CFG_BASE+4i, i < NUM_CFG_REGS: write and set dirty[i].
  - LOT_BASE+4j, j < NUM_LOT_REG: write and set dirty[NUM_CFG_REGS+j].
  - Any other address, or an unaligned address: silently dropped.
- Dirty vector: D has NUM_CFG_REGS+NUM_LOT_REG bits.
  - read_addr is the address of the lowest set index in D, or 12'h000 if D is zero.
  - irq = |D, driven from flops only.
- Wishbone, single-cycle combinational response while cyc & stb:
  - we=1: err=1, ack=0.
  - 12'h000: return {20'b0, read_addr}; ack.
  - A valid CFG or LOT address: return the value, ack, and clear that dirty bit at the next edge.
  - Anything else, including MAXCLKCNT_ADDR: err=1.
  - wb_data_out is 0 whenever ack is low.
- Simultaneous debug write and Wishbone read of the same register in one cycle: the read returns the old value and the dirty bit ends up SET (the set wins).
- Rewriting a register that is still dirty overwrites its value; the flag stays set.
- rst_n asserted mid-packet aborts the packet. Remaining flits of that packet are absorbed via DRAIN only if a later packet restarts with the FSM out of sync; this is an accepted limitation.

Optional Feature:
- Macro SM_CONFIG_REGFILE_OVERRUN_EN.
- With it defined: an 8-bit saturating counter increments on every debug write to a CFG/LOT register whose dirty bit is already set and not being cleared in the same cycle.
  - Readable at Wishbone 12'h004 as {24'b0, cnt}.
  - The read clears the counter at the next edge; an increment in the same cycle wins and leaves the count at 1.
- Without it: 12'h004 returns err and no counter logic exists.

Decomposition:
- Shared package sm_config_pkg:
  - REG_ADDR (12'h000), REG_OVERRUN (12'h004) and the default base-address localparams.
  - The FSM state enum typedef.
  - A function lot_words(num_tiles).
- One natural sub-module, sm_dirty_prienc: a parametrised priority encoder taking D and returning the index and a valid bit.

Test Plan:
1. Debug packet {0x0304, 0xBEEF, 0xDEAD(last)}:
   - cfg_regs[1]=0xDEADBEEF and irq=1 one cycle after the last flit.
   - WB read 0x000 returns 0x304.
   - WB read 0x304 returns 0xDEADBEEF; irq=0 next cycle.
2. Write cfg 5 (0x314), then cfg 0 (0x300), then LOT 0 (0x400); NUM_TILES=40 so LOT has 2 words:
   - Successive REG_ADDR/read pairs yield 0x300, 0x314, 0x400, then 0x000 with irq=0.
3. 4-flit packet to 0x300 (extra flit before last) -> no write, dirty stays 0, FSM in ADDR after the last flit. WB write to 0x300 -> err=1, ack=0.
4. Same-cycle WB read of 0x308 and last debug flit writing 0x308 with 0x12345678:
   - Read returns the old value.
   - dirty remains set; the next read returns 0x12345678.
5. OVERRUN_EN: write 0x300 three times without reading -> read 0x004 returns 2; the next read returns 0. WB read 0x408 with NUM_LOT_REG=2 -> err=1.
6. Assert rst_n=0 asynchronously after the LOW flit -> all outputs and registers 0, irq=0, with no clock edge required.
